// File: rtl/jtdsp16_pio_host.sv
// Host-side bridge for the jtdsp16 parallel I/O port: DSP output words land in an
// RX FIFO, host words queue in a TX FIFO read by the DSP, plus irq and sticky error flags.
module jtdsp16_pio_host #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [15:0]   pbus_out,
    input  logic          pods_n,
    input  logic          pids_n,
    input  logic          psel,
    input  logic          iack,
    output logic [15:0]   pbus_in,
    output logic          irq,
    output logic [15:0]   rx_data,
    output logic          rx_sel,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic [15:0]   tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    input  logic          irq_req,
    output logic [AW:0]   rx_level,
    output logic [AW:0]   tx_level,
    output logic          rx_ovf,
    output logic          tx_udf,
    input  logic          clr_err
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

    // Handshake: a host transfer happens on a clock edge where valid & ready & cen are
    // all high; ready never depends on valid, and valid may be raised at any time.

    logic          pods_q, pids_q;
    logic          wr_ev, rd_ev;
    logic [16:0]   rx_mem [DEPTH];
    logic [15:0]   tx_mem [DEPTH];
    logic [AW-1:0] rx_wptr_q, rx_rptr_q, tx_wptr_q, tx_rptr_q, tx_rptr_nx;
    logic [AW:0]   rx_level_q, rx_level_d, tx_level_q, tx_level_d;
    logic          rx_push, rx_pop, rx_drop, tx_push, tx_pop, tx_empty_rd;
    logic [15:0]   pbus_in_q, pbus_in_d;
    logic          irq_q, irq_d, rx_ovf_q, rx_ovf_d, tx_udf_q, tx_udf_d;
    logic [16:0]   rx_head;

    // Rising edge of an active-low strobe marks the end of a DSP transfer.
    assign wr_ev = cen & pods_n & ~pods_q;
    assign rd_ev = cen & pids_n & ~pids_q;

    assign rx_head  = rx_mem[rx_rptr_q];
    assign rx_data  = rx_head[15:0];
    assign rx_sel   = rx_head[16];
    assign rx_valid = (rx_level_q != '0);
    assign tx_ready = (tx_level_q != FULL_LVL);

    assign rx_pop      = cen & rx_valid & rx_ready;
    assign rx_push     = wr_ev & ((rx_level_q != FULL_LVL) | rx_pop);
    assign rx_drop     = wr_ev & ~rx_push;
    assign tx_push     = cen & tx_valid & tx_ready;
    assign tx_pop      = rd_ev & (tx_level_q != '0);
    assign tx_empty_rd = rd_ev & (tx_level_q == '0);

    assign rx_level_d = rx_level_q + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
    assign tx_level_d = tx_level_q + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
    assign tx_rptr_nx = tx_pop ? tx_rptr_q + AW'(1) : tx_rptr_q;

    // pbus_in tracks the post-update head; a word pushed into the head slot this
    // cycle is not yet in memory, so it is forwarded from tx_data.
    always_comb begin
        pbus_in_d = pbus_in_q;
        if (tx_level_d != '0) begin
            if (tx_push && (tx_wptr_q == tx_rptr_nx)) pbus_in_d = tx_data;
            else                                      pbus_in_d = tx_mem[tx_rptr_nx];
        end
    end

    always_comb begin
        irq_d = irq_q;
        if (iack || rd_ev) irq_d = 1'b0;
        if (irq_req)       irq_d = 1'b1;
        rx_ovf_d = rx_ovf_q;
        tx_udf_d = tx_udf_q;
        if (clr_err) begin
            rx_ovf_d = 1'b0;
            tx_udf_d = 1'b0;
        end
        if (rx_drop)     rx_ovf_d = 1'b1;
        if (tx_empty_rd) tx_udf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q] <= {psel, pbus_out};
        if (tx_push) tx_mem[tx_wptr_q] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pods_q     <= 1'b1;
            pids_q     <= 1'b1;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_level_q <= '0;
            pbus_in_q  <= 16'h0000;
            irq_q      <= 1'b0;
            rx_ovf_q   <= 1'b0;
            tx_udf_q   <= 1'b0;
        end else if (cen) begin
            pods_q     <= pods_n;
            pids_q     <= pids_n;
            if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
            rx_level_q <= rx_level_d;
            if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
            tx_rptr_q  <= tx_rptr_nx;
            tx_level_q <= tx_level_d;
            pbus_in_q  <= pbus_in_d;
            irq_q      <= irq_d;
            rx_ovf_q   <= rx_ovf_d;
            tx_udf_q   <= tx_udf_d;
        end
    end

    assign pbus_in  = pbus_in_q;
    assign irq      = irq_q;
    assign rx_level = rx_level_q;
    assign tx_level = tx_level_q;
    assign rx_ovf   = rx_ovf_q;
    assign tx_udf   = tx_udf_q;
endmodule

// File: tb/tb_jtdsp16_pio_host.sv
// Directed self-checking bench for jtdsp16_pio_host (AW=3, 8-entry FIFOs).
module tb_jtdsp16_pio_host;
    logic        clk, rst_n, cen;
    logic [15:0] pbus_out, pbus_in, rx_data, tx_data;
    logic        pods_n, pids_n, psel, iack, irq, rx_sel, rx_valid, rx_ready;
    logic        tx_valid, tx_ready, irq_req, rx_ovf, tx_udf, clr_err;
    logic [3:0]  rx_level, tx_level;
    int          checks = 0;
    int          failures = 0;

    jtdsp16_pio_host #(.AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .pbus_out(pbus_out), .pods_n(pods_n),
        .pids_n(pids_n), .psel(psel), .iack(iack), .pbus_in(pbus_in), .irq(irq),
        .rx_data(rx_data), .rx_sel(rx_sel), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq_req(irq_req),
        .rx_level(rx_level), .tx_level(tx_level), .rx_ovf(rx_ovf), .tx_udf(tx_udf),
        .clr_err(clr_err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic dsp_write(input logic [15:0] d, input logic s, input int low_cycles);
        pbus_out = d;
        psel     = s;
        pods_n   = 1'b0;
        repeat (low_cycles) tick();
        pods_n = 1'b1;
        tick();
    endtask

    task automatic dsp_read();
        pids_n = 1'b0;
        tick();
        pids_n = 1'b1;
        tick();
    endtask

    task automatic host_push(input logic [15:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic host_pop();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cen = 1'b1; pbus_out = '0; pods_n = 1'b1; pids_n = 1'b1;
        psel = 1'b0; iack = 1'b0; rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
        irq_req = 1'b0; clr_err = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (rx_level !== 4'd0 || rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx level=%0d valid=%b exp 0/0", rx_level, rx_valid); end
        checks++; if (tx_level !== 4'd0 || tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx level=%0d ready=%b exp 0/1", tx_level, tx_ready); end
        checks++; if (pbus_in !== 16'h0000 || irq !== 1'b0) begin failures++; $display("FAIL reset_out pbus_in=%h irq=%b exp 0000/0", pbus_in, irq); end
        checks++; if (rx_ovf !== 1'b0 || tx_udf !== 1'b0) begin failures++; $display("FAIL reset_err ovf=%b udf=%b exp 0/0", rx_ovf, tx_udf); end
    endtask

    task automatic test_capture();
        dsp_write(16'hcafe, 1'b1, 3);
        checks++; if (rx_level !== 4'd1 || rx_data !== 16'hcafe || rx_sel !== 1'b1) begin failures++; $display("FAIL cap_word level=%0d data=%h sel=%b exp 1/cafe/1", rx_level, rx_data, rx_sel); end
        repeat (3) tick();
        checks++; if (rx_level !== 4'd1) begin failures++; $display("FAIL cap_single level=%0d exp 1", rx_level); end
        host_pop();
        checks++; if (rx_level !== 4'd0 || rx_valid !== 1'b0) begin failures++; $display("FAIL cap_pop level=%0d valid=%b exp 0/0", rx_level, rx_valid); end
    endtask

    task automatic test_tx();
        host_push(16'hbeef);
        checks++; if (pbus_in !== 16'hbeef || tx_level !== 4'd1) begin failures++; $display("FAIL tx_push1 pbus_in=%h level=%0d exp beef/1", pbus_in, tx_level); end
        host_push(16'hbef0);
        checks++; if (pbus_in !== 16'hbeef || tx_level !== 4'd2) begin failures++; $display("FAIL tx_push2 pbus_in=%h level=%0d exp beef/2", pbus_in, tx_level); end
        dsp_read();
        checks++; if (pbus_in !== 16'hbef0 || tx_level !== 4'd1) begin failures++; $display("FAIL tx_read1 pbus_in=%h level=%0d exp bef0/1", pbus_in, tx_level); end
        dsp_read();
        checks++; if (pbus_in !== 16'hbef0 || tx_level !== 4'd0 || tx_udf !== 1'b0) begin failures++; $display("FAIL tx_read2 pbus_in=%h level=%0d udf=%b exp bef0/0/0", pbus_in, tx_level, tx_udf); end
    endtask

    task automatic test_rx_overflow();
        for (int i = 1; i <= 9; i++) dsp_write(16'(i), 1'b0, 1);
        checks++; if (rx_level !== 4'd8 || rx_ovf !== 1'b1) begin failures++; $display("FAIL ovf_fill level=%0d ovf=%b exp 8/1", rx_level, rx_ovf); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (rx_data !== 16'(i) || rx_sel !== 1'b0) begin failures++; $display("FAIL ovf_drain[%0d] data=%h sel=%b exp %h/0", i, rx_data, rx_sel, 16'(i)); end
            host_pop();
        end
        checks++; if (rx_level !== 4'd0 || rx_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky level=%0d ovf=%b exp 0/1", rx_level, rx_ovf); end
        pulse_clr();
        checks++; if (rx_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear ovf=%b exp 0", rx_ovf); end
    endtask

    task automatic test_underflow_irq();
        dsp_read();
        checks++; if (tx_udf !== 1'b1 || pbus_in !== 16'hbef0) begin failures++; $display("FAIL udf_set udf=%b pbus_in=%h exp 1/bef0", tx_udf, pbus_in); end
        pulse_clr();
        checks++; if (tx_udf !== 1'b0) begin failures++; $display("FAIL udf_clear udf=%b exp 0", tx_udf); end
        // error event and clr_err in the same cycle: flag ends set
        pids_n = 1'b0;
        tick();
        pids_n = 1'b1; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (tx_udf !== 1'b1) begin failures++; $display("FAIL udf_vs_clr udf=%b exp 1", tx_udf); end
        pulse_clr();
        irq_req = 1'b1; tick(); irq_req = 1'b0;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set irq=%b exp 1", irq); end
        tick();
        iack = 1'b1; tick(); iack = 1'b0;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_iack irq=%b exp 0", irq); end
        pids_n = 1'b0;
        tick();
        pids_n = 1'b1; irq_req = 1'b1;
        tick();
        irq_req = 1'b0;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins irq=%b exp 1", irq); end
        dsp_read();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_read_clr irq=%b exp 0", irq); end
        pulse_clr();
    endtask

    task automatic test_tx_full();
        for (int i = 0; i < 8; i++) host_push(16'h0100 + 16'(i));
        checks++; if (tx_level !== 4'd8 || tx_ready !== 1'b0 || pbus_in !== 16'h0100) begin failures++; $display("FAIL txf_fill level=%0d ready=%b pbus_in=%h exp 8/0/0100", tx_level, tx_ready, pbus_in); end
        host_push(16'hdead);
        checks++; if (tx_level !== 4'd8 || pbus_in !== 16'h0100) begin failures++; $display("FAIL txf_refuse level=%0d pbus_in=%h exp 8/0100", tx_level, pbus_in); end
        for (int i = 1; i <= 8; i++) begin
            dsp_read();
            checks++; if (pbus_in !== 16'h0100 + 16'((i < 8) ? i : 7) || tx_level !== 4'(8 - i)) begin failures++; $display("FAIL txf_drain[%0d] pbus_in=%h level=%0d exp %h/%0d", i, pbus_in, tx_level, 16'h0100 + 16'((i < 8) ? i : 7), 8 - i); end
        end
        checks++; if (tx_udf !== 1'b0) begin failures++; $display("FAIL txf_no_udf udf=%b exp 0", tx_udf); end
    endtask

    task automatic test_rx_full_pushpop();
        logic [15:0] exp_q[$];
        for (int i = 0; i < 8; i++) begin
            dsp_write(16'h0010 + 16'(i), 1'b1, 1);
            exp_q.push_back(16'h0010 + 16'(i));
        end
        pbus_out = 16'h0018; psel = 1'b1; pods_n = 1'b0;
        tick();
        pods_n = 1'b1; rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(16'h0018);
        checks++; if (rx_level !== 4'd8 || rx_ovf !== 1'b0) begin failures++; $display("FAIL fullpp_level level=%0d ovf=%b exp 8/0", rx_level, rx_ovf); end
        while (exp_q.size() > 0) begin
            checks++; if (rx_data !== exp_q[0]) begin failures++; $display("FAIL fullpp_order data=%h exp %h", rx_data, exp_q[0]); end
            void'(exp_q.pop_front());
            host_pop();
        end
        checks++; if (rx_level !== 4'd0) begin failures++; $display("FAIL fullpp_empty level=%0d exp 0", rx_level); end
    endtask

    task automatic test_cen_gap();
        pbus_out = 16'h55aa; psel = 1'b0; pods_n = 1'b0;
        tick();
        cen = 1'b0; pods_n = 1'b1;
        repeat (2) tick();
        checks++; if (rx_level !== 4'd0) begin failures++; $display("FAIL cen_frozen level=%0d exp 0", rx_level); end
        cen = 1'b1;
        tick();
        checks++; if (rx_level !== 4'd1 || rx_data !== 16'h55aa) begin failures++; $display("FAIL cen_capture level=%0d data=%h exp 1/55aa", rx_level, rx_data); end
        repeat (2) tick();
        checks++; if (rx_level !== 4'd1) begin failures++; $display("FAIL cen_once level=%0d exp 1", rx_level); end
        cen = 1'b0; rx_ready = 1'b1;
        tick();
        checks++; if (rx_level !== 4'd1) begin failures++; $display("FAIL cen_nopop level=%0d exp 1", rx_level); end
        cen = 1'b1;
        tick();
        rx_ready = 1'b0;
        checks++; if (rx_level !== 4'd0) begin failures++; $display("FAIL cen_pop level=%0d exp 0", rx_level); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            dsp_write(16'h0a00 + 16'(i), 1'b0, 1);
            host_push(16'h0b00 + 16'(i));
        end
        irq_req = 1'b1; tick(); irq_req = 1'b0;
        checks++; if (rx_level !== 4'd5 || tx_level !== 4'd5 || irq !== 1'b1 || pbus_in !== 16'h0b00) begin failures++; $display("FAIL arst_pre rx=%0d tx=%0d irq=%b pbus_in=%h exp 5/5/1/0b00", rx_level, tx_level, irq, pbus_in); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rx_level !== 4'd0 || tx_level !== 4'd0 || irq !== 1'b0 || pbus_in !== 16'h0000) begin failures++; $display("FAIL arst_now rx=%0d tx=%0d irq=%b pbus_in=%h exp 0/0/0/0000", rx_level, tx_level, irq, pbus_in); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (rx_valid !== 1'b0 || tx_ready !== 1'b1) begin failures++; $display("FAIL arst_after valid=%b ready=%b exp 0/1", rx_valid, tx_ready); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_tx();
        test_rx_overflow();
        test_underflow_irq();
        test_tx_full();
        test_rx_full_pushpop();
        test_cen_gap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtdsp16_pio_host.md
Name: jtdsp16_pio_host

Overview:
- Host-side bridge on the jtdsp16 parallel I/O port; directly downstream of pbus_out/pods_n and upstream of pbus_in/pids_n/irq.
- Captures every DSP parallel output word into an RX FIFO; host pushes words into a TX FIFO that the DSP reads through pids_n.
- Drives the DSP irq line from host requests; clears it on acknowledge.

Parameters:
- AW, 3, FIFO address width; each FIFO holds 2**AW entries.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state updates and host transfers are qualified by cen=1
- pbus_out  in  16  DSP parallel output data
- pods_n  in  1  DSP output data strobe, active low
- pids_n  in  1  DSP input data strobe, active low
- psel  in  1  DSP peripheral select
- iack  in  1  DSP interrupt acknowledge
- pbus_in  out  16  data presented to the DSP
- irq  out  1  DSP interrupt request
- rx_data  out  16  RX FIFO head word
- rx_sel  out  1  psel captured with rx_data
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  host pops RX head when rx_valid & rx_ready & cen
- tx_data  in  16  host word for the DSP
- tx_valid  in  1  host push request
- tx_ready  out  1  TX FIFO not full
- irq_req  in  1  host interrupt request pulse
- rx_level  out  AW+1  RX occupancy
- tx_level  out  AW+1  TX occupancy
- rx_ovf  out  1  sticky: DSP write dropped because RX was full
- tx_udf  out  1  sticky: DSP read while TX was empty
- clr_err  in  1  clears rx_ovf and tx_udf

Behaviour:
- Reset (async, rst_n=0): both FIFOs empty; pbus_in=16'h0000; irq=0; rx_ovf=tx_udf=0; internal pods_n/pids_n history registers=1.
- Mid-operation reset: all contents are discarded immediately, with no partial push or pop.
- Edge detection:
  - pods_n and pids_n are registered each cen cycle.
  - Write event = pods_n==1 and previous==0.
  - Read event = pids_n==1 and previous==0.
  - A strobe held low for many cycles produces exactly one event.
- Write event:
  - If RX is not full, or a host pop occurs in the same cycle, push {psel, pbus_out} sampled in that cycle.
  - Otherwise drop the word and set rx_ovf.
- RX host side:
  - rx_data, rx_sel and rx_valid are combinational from the FIFO head.
  - A pop advances the head at the clock edge.
  - Simultaneous push and pop leaves rx_level unchanged.
- TX host side:
  - tx_ready = (tx_level != 2**AW); there is no full bypass.
  - A push occurs when tx_valid & tx_ready & cen.
- Read event:
  - If TX is not empty, pop the head.
  - If TX is empty, set tx_udf and leave pbus_in unchanged.
  - A host push and a DSP pop in the same cycle are both accepted.
- pbus_in is a register.
  - After any edge where the TX FIFO is non-empty, it holds the post-update head.
  - When TX becomes or stays empty, it holds its last value.
  - A push into an empty FIFO at edge N is visible on pbus_in right after edge N.
  - A pop at edge N exposes the next word after edge N.
- irq:
  - Set on irq_req (cen=1).
  - Cleared on iack=1 or on a read event.
  - If set and clear occur in the same cycle, set wins.
- Error flags:
  - clr_err clears both sticky flags.
  - If an error event and clr_err occur in the same cycle, the flag ends set.
- Pointers are AW-bit and wrap modulo 2**AW; full/empty are derived from the level counters.
- cen=0 freezes every register, including strobe history, so no event is lost or duplicated across cen gaps.

Test Plan:
- Reset, then pulse pods_n low for 3 cycles with pbus_out=16'hcafe, psel=1 -> rx_level=1, rx_data=16'hcafe, rx_sel=1; exactly one entry.
- Host pushes 16'hbeef, 16'hbef0; DSP pulses pids_n twice -> pbus_in=16'hbeef after the push, 16'hbef0 after the first read; after the second read tx_level=0 and pbus_in stays 16'hbef0.
- AW=3: 9 DSP writes 16'h0001..16'h0009 with rx_ready=0 -> rx_level=8, rx_ovf=1, host drains 16'h0001..16'h0008 in order; then clr_err -> rx_ovf=0.
- DSP read with TX empty -> tx_udf=1, pbus_in unchanged. irq_req pulse -> irq=1; iack -> irq=0. irq_req in the same cycle as a read event -> irq=1.
- Fill TX to 8 (tx_ready=0); push attempt with tx_valid=1 is refused. Same-cycle RX push/pop at full keeps rx_level=8 with correct order. Toggle cen=0 during a pods_n pulse -> exactly one capture.
- Assert rst_n=0 with 5 entries in each FIFO and irq=1 -> all levels 0, irq=0, pbus_in=16'h0000 without waiting for a clock.
